// File: rtl/rtc_bus_seq.sv
// Multiplexed-bus sequencer for an RTC chip: address phase, CS-high gap, then data phase.
// Every output is a flop loaded from the decode of the next state.
module rtc_bus_seq #(
  parameter int DATA_W  = 8,
  parameter int T_SETUP = 1,
  parameter int T_CS    = 6,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 12,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic              abort,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              ad,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_A_SETUP  = 3'd1;
  localparam logic [2:0] ST_A_STROBE = 3'd2;
  localparam logic [2:0] ST_A_HOLD   = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;
  localparam logic [2:0] ST_D_STROBE = 3'd5;
  localparam logic [2:0] ST_D_HOLD   = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  logic [2:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept, expired, entry, capture;
  logic              rw_q, rw_l;
  logic [DATA_W-1:0] addr_q, addr_l, wdata_q, wdata_l;

  logic              cs_d, wr_d, rd_d, ad_d, oe_d, busy_d, done_d;
  logic [DATA_W-1:0] bo_d;

  // Counter holds (cycles remaining - 1) in the current state.
  function automatic logic [CNT_W-1:0] load_for(input logic [2:0] s);
    case (s)
      ST_A_SETUP:             load_for = CNT_W'(T_SETUP - 1);
      ST_A_STROBE, ST_D_STROBE: load_for = CNT_W'(T_CS - 1);
      ST_A_HOLD, ST_D_HOLD:   load_for = CNT_W'(T_HOLD - 1);
      ST_GAP:                 load_for = CNT_W'(T_GAP - 1);
      default:                load_for = '0;
    endcase
  endfunction

  // Handshake: start is a level request sampled only in IDLE or DONE (busy low);
  // abort in the same cycle suppresses acceptance, otherwise start is ignored.
  always_comb begin
    accept   = start && !abort && (state == ST_IDLE || state == ST_DONE);
    expired  = (cnt == '0);
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_A_SETUP;
      ST_DONE: state_nx = accept ? ST_A_SETUP : ST_IDLE;
      default: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (expired) begin
          case (state)
            ST_A_SETUP:  state_nx = ST_A_STROBE;
            ST_A_STROBE: state_nx = ST_A_HOLD;
            ST_A_HOLD:   state_nx = ST_GAP;
            ST_GAP:      state_nx = ST_D_STROBE;
            ST_D_STROBE: state_nx = ST_D_HOLD;
            ST_D_HOLD:   state_nx = ST_DONE;
            default:     state_nx = ST_IDLE;
          endcase
        end
      end
    endcase
    entry   = (state_nx != state);
    cnt_nx  = entry ? load_for(state_nx) : (expired ? cnt : cnt - 1'b1);
    capture = (state == ST_D_STROBE) && expired && !abort && rw_q;
    rw_l    = accept ? rw    : rw_q;
    addr_l  = accept ? addr  : addr_q;
    wdata_l = accept ? wdata : wdata_q;
  end

  always_comb begin
    cs_d   = 1'b1;
    wr_d   = 1'b1;
    rd_d   = 1'b1;
    ad_d   = 1'b1;
    oe_d   = 1'b0;
    bo_d   = '0;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_nx)
      ST_IDLE: busy_d = 1'b0;
      ST_A_SETUP, ST_A_HOLD: begin
        ad_d = 1'b0;
        oe_d = 1'b1;
        bo_d = addr_l;
      end
      ST_A_STROBE: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        ad_d = 1'b0;
        oe_d = 1'b1;
        bo_d = addr_l;
      end
      ST_GAP, ST_D_HOLD: begin
        if (!rw_l) begin
          oe_d = 1'b1;
          bo_d = wdata_l;
        end
      end
      ST_D_STROBE: begin
        cs_d = 1'b0;
        if (rw_l) begin
          rd_d = 1'b0;
        end else begin
          wr_d = 1'b0;
          oe_d = 1'b1;
          bo_d = wdata_l;
        end
      end
      ST_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      ad      <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rw_q    <= rw_l;
      addr_q  <= addr_l;
      wdata_q <= wdata_l;
      if (capture) rdata <= bus_in;
      cs_n    <= cs_d;
      wr_n    <= wr_d;
      rd_n    <= rd_d;
      ad      <= ad_d;
      bus_oe  <= oe_d;
      bus_out <= bo_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Bench for rtc_bus_seq: default-timing 8-bit instance and all-ones-timing 16-bit instance,
// checked cycle by cycle against a phase-boundary model of the bus transaction.
module tb_rtc_bus_seq;

  localparam int A_S = 1, A_C = 6, A_H = 1, A_G = 12;
  localparam int B_S = 1, B_C = 1, B_H = 1, B_G = 1;

  logic clk = 1'b0;
  logic reset, start, rw, abort, sel;
  logic [15:0] addr, wdata, bus_in;
  logic start_a, start_b;

  logic        cs_n_a, wr_n_a, rd_n_a, ad_a, oe_a, busy_a, done_a;
  logic [7:0]  bus_out_a, rdata_a;
  logic [2:0]  st_a;
  logic        cs_n_b, wr_n_b, rd_n_b, ad_b, oe_b, busy_b, done_b;
  logic [15:0] bus_out_b, rdata_b;
  logic [2:0]  st_b;

  logic [6:0]  o_ctl;
  logic [15:0] o_bus_out, o_rdata;
  logic [15:0] rdata_exp [2];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  rtc_bus_seq #(.DATA_W(8), .T_SETUP(A_S), .T_CS(A_C), .T_HOLD(A_H), .T_GAP(A_G)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rw(rw), .abort(abort),
    .addr(addr[7:0]), .wdata(wdata[7:0]), .bus_in(bus_in[7:0]),
    .cs_n(cs_n_a), .wr_n(wr_n_a), .rd_n(rd_n_a), .ad(ad_a), .bus_out(bus_out_a),
    .bus_oe(oe_a), .rdata(rdata_a), .busy(busy_a), .done(done_a), .state_dbg(st_a));

  rtc_bus_seq #(.DATA_W(16), .T_SETUP(B_S), .T_CS(B_C), .T_HOLD(B_H), .T_GAP(B_G)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rw(rw), .abort(abort),
    .addr(addr), .wdata(wdata), .bus_in(bus_in),
    .cs_n(cs_n_b), .wr_n(wr_n_b), .rd_n(rd_n_b), .ad(ad_b), .bus_out(bus_out_b),
    .bus_oe(oe_b), .rdata(rdata_b), .busy(busy_b), .done(done_b), .state_dbg(st_b));

  always_comb begin
    if (sel) begin
      o_ctl     = {cs_n_b, wr_n_b, rd_n_b, ad_b, oe_b, busy_b, done_b};
      o_bus_out = bus_out_b;
      o_rdata   = rdata_b;
    end else begin
      o_ctl     = {cs_n_a, wr_n_a, rd_n_a, ad_a, oe_a, busy_a, done_a};
      o_bus_out = {8'h00, bus_out_a};
      o_rdata   = {8'h00, rdata_a};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {cs_n, wr_n, rd_n, ad, bus_oe, busy, done} for cycle k after the start edge
  // (k=0 means idle).
  function automatic logic [6:0] exp_ctl(input int k, input logic r, input int s, input int c,
                                         input int h, input int g);
    int p1, p2, p3, p4, p5, p6;
    p1 = s; p2 = p1 + c; p3 = p2 + h; p4 = p3 + g; p5 = p4 + c; p6 = p5 + h;
    if (k == 0)       return 7'b1111000;
    else if (k <= p1) return 7'b1110110;
    else if (k <= p2) return 7'b0010110;
    else if (k <= p3) return 7'b1110110;
    else if (k <= p4) return {4'b1111, ~r, 2'b10};
    else if (k <= p5) return {1'b0, r, ~r, 1'b1, ~r, 2'b10};
    else if (k <= p6) return {4'b1111, ~r, 2'b10};
    else              return 7'b1111001;
  endfunction

  function automatic int total_cycles();
    if (sel) return B_S + 2 * B_C + 2 * B_H + B_G;
    else     return A_S + 2 * A_C + 2 * A_H + A_G;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, " ctl"}, {25'd0, o_ctl}, {25'd0, exp_ctl(0, 1'b0, 1, 1, 1, 1)});
    chk({tag, " rdata"}, {16'd0, o_rdata}, {16'd0, rdata_exp[sel]});
  endtask

  task automatic check_reset(input string tag);
    check_idle(tag);
    chk({tag, " bus_out"}, {16'd0, o_bus_out}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      @(posedge clk); #1;
      check_idle("idle");
    end
  endtask

  // Called in an IDLE or DONE cycle at posedge+1; returns in the DONE cycle, or in
  // the IDLE cycle following an abort/reset at cycle kill_at.
  task automatic run_txn(input logic t_rw, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                         input int kill_at, input int kill_kind, input logic hold,
                         input logic fix_en, input logic [15:0] fix_val);
    int s, c, h, g, p3, p4, p5, total;
    logic [15:0] mask, a_m, w_m;
    logic [6:0] e;
    if (sel) begin s = B_S; c = B_C; h = B_H; g = B_G; end
    else     begin s = A_S; c = A_C; h = A_H; g = A_G; end
    p3 = s + c + h; p4 = p3 + g; p5 = p4 + c; total = p5 + h;
    mask = sel ? 16'hffff : 16'h00ff;
    a_m = t_addr & mask;
    w_m = t_wdata & mask;
    rw = t_rw; addr = t_addr; wdata = t_wdata; abort = 1'b0; start = 1'b1;
    for (int k = 1; k <= total + 1; k++) begin
      @(posedge clk); #1;
      e = exp_ctl(k, t_rw, s, c, h, g);
      chk($sformatf("ctl k=%0d rw=%0b", k, t_rw), {25'd0, o_ctl}, {25'd0, e});
      chk($sformatf("rdata k=%0d", k), {16'd0, o_rdata}, {16'd0, rdata_exp[sel]});
      if (e[2]) chk($sformatf("bus_out k=%0d", k), {16'd0, o_bus_out}, {16'd0, (k <= p3) ? a_m : w_m});
      if (k == kill_at) begin
        if (kill_kind == 0) begin
          abort = 1'b1;
          start = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          abort = 1'b0;
          start = 1'b0;
          check_idle("after abort");
        end else begin
          #2 reset = 1'b1;
          #1;
          rdata_exp[0] = '0;
          rdata_exp[1] = '0;
          start = 1'b0;
          check_reset("async reset");
          @(posedge clk); #1;
          reset = 1'b0;
          check_reset("reset release");
        end
        return;
      end
      bus_in = (fix_en && k > p4 && k <= p5) ? fix_val : 16'($urandom);
      if (t_rw && k == p5) rdata_exp[sel] = bus_in & mask;
      if (k <= total) begin
        start = hold | 1'($urandom_range(0, 1));
        rw    = hold ? 1'b0 : 1'($urandom_range(0, 1));
        addr  = 16'($urandom);
        wdata = 16'($urandom);
      end else begin
        start = hold;
      end
    end
  endtask

  initial begin
    int kill;
    reset = 1'b1; start = 1'b0; rw = 1'b0; abort = 1'b0; sel = 1'b0;
    addr = '0; wdata = '0; bus_in = '0;
    rdata_exp[0] = '0;
    rdata_exp[1] = '0;
    #1 check_reset("reset a");
    sel = 1'b1;
    #1 check_reset("reset b");
    sel = 1'b0;
    #20;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);

    // Directed write and read on the default-timing instance.
    run_txn(1'b0, 16'h0021, 16'h005A, 0, 0, 1'b0, 1'b0, 16'h0);
    idle_cycles(1);
    run_txn(1'b1, 16'h000C, 16'h00EE, 0, 0, 1'b0, 1'b1, 16'h0037);
    chk("rdata after read", {16'd0, o_rdata}, 32'h37);
    idle_cycles(1);
    // Read aborted in its first GAP cycle keeps the old rdata.
    run_txn(1'b1, 16'h0044, 16'h0000, A_S + A_C + A_H + 1, 0, 1'b0, 1'b0, 16'h0);
    chk("rdata after abort", {16'd0, o_rdata}, 32'h37);
    idle_cycles(2);
    // start held high: back-to-back writes.
    for (int i = 0; i < 3; i++) run_txn(1'b0, 16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0, 16'h0);
    idle_cycles(2);
    // Reset mid D_STROBE of a write, then a complete write.
    run_txn(1'b0, 16'h0055, 16'h00AA, A_S + A_C + A_H + A_G + 3, 1, 1'b0, 1'b0, 16'h0);
    run_txn(1'b0, 16'h0012, 16'h0034, 0, 0, 1'b0, 1'b0, 16'h0);
    idle_cycles(1);

    for (int i = 0; i < 25; i++) begin
      kill = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, total_cycles())) : 0;
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), kill, 0, 1'b0, 1'b0, 16'h0);
      if (kill == 0) idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(1);

    // 16-bit instance with every timing parameter at 1.
    sel = 1'b1;
    #1 check_idle("b idle");
    run_txn(1'b0, 16'hBEEF, 16'hCAFE, 0, 0, 1'b0, 1'b0, 16'h0);
    idle_cycles(1);
    run_txn(1'b1, 16'h1234, 16'h0, 0, 0, 1'b0, 1'b1, 16'hA5C3);
    chk("b rdata 16-bit", {16'd0, o_rdata}, 32'hA5C3);
    for (int i = 0; i < 2; i++) run_txn(1'b0, 16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0, 16'h0);
    idle_cycles(1);
    for (int i = 0; i < 12; i++) begin
      kill = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total_cycles())) : 0;
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), kill, 0, 1'b0, 1'b0, 16'h0);
      if (kill == 0) idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
